accum4_extender: RTL
====================

# accum4_extender

Downstream companion to `accum4`. It observes the same `en`/`in_data` stream that drives `accum4` and the `accum` value it produces, and reconstructs the carries lost to `accum4`'s 4-bit wrap. It extends the running sum to `4+HI_W` bits and publishes a windowed snapshot (total plus wrap count) over a valid/ready handshake. It sits between `accum4` and any consumer that needs the full-precision total.

## Interface
- `HI_W`, default 4: number of extension bits above `accum4`'s 4 bits; `total` is `4+HI_W` bits wide.
- `WINDOW`, default 4: number of enabled samples per snapshot; must be ≥1.

- `clk` input, 1 bit: single clock, shared with `accum4`.
- `rst` input, 1 bit: synchronous, active-high reset. `accum4`'s `rst_n` is driven from `~rst` at the parent, so both reset on the same edge.
- `en` input, 1 bit: same net as `accum4.en`.
- `in_data` input, 4 bits: same net as `accum4.in_data`.
- `accum` input, 4 bits: `accum4.accum`, the pre-update value in the current cycle.
- `out_valid` output, 1 bit: snapshot held.
- `out_ready` input, 1 bit: consumer accepts.
- `out_total` output, `4+HI_W` bits: `{hi, lo}` total at end of the window.
- `out_wraps` output, `$clog2(WINDOW+1)` bits: carries detected within the window.
- `out_overrun` output, 1 bit: sticky; set when an unaccepted snapshot was overwritten.

## Operation
- Each cycle with `rst=0` and `en=1`:
  - `sum5 = accum + in_data` (5-bit).
  - `carry = sum5[4]`.
  - `hi <= hi + carry` (mod 2^HI_W).
  - `win_wraps += carry`.
  - `win_cnt += 1`.
- Cycles with `en=0` change no state except the output handshake.
- When `en=1` and `win_cnt==WINDOW-1`:
  - Form a snapshot: `total = {hi + carry, sum5[3:0]}` and `wraps = win_wraps + carry`.
  - Clear `win_cnt` and `win_wraps` to 0.
  - Load the snapshot into the output register.
- Output FSM, two states:
  - EMPTY → HOLD on snapshot load.
  - HOLD → EMPTY on `out_valid && out_ready` when no snapshot loads in the same cycle.
  - HOLD stays HOLD on handshake plus simultaneous load: old data is transferred, new data is loaded, no overrun.
  - HOLD with a load and no handshake: new data overwrites (latest wins), `out_overrun <= 1`.
- `out_total` and `out_wraps` remain stable while `out_valid=1` and no overwrite occurs.
- `out_overrun` clears only on `rst`.
- `hi` and `lo` have no dependency on the handshake. Backpressure never stalls accumulation.

## Timing
- Reset values: `out_valid=0`, `out_total=0`, `out_wraps=0`, `out_overrun=0`, `hi=0`, `win_cnt=0`, `win_wraps=0`, FSM=EMPTY.
- Latency: `out_valid` rises the cycle after the edge that samples the WINDOW-th enabled sample, coincident with `accum4.accum` showing the same `lo`.
- Throughput: one snapshot per WINDOW enabled cycles. With WINDOW=1, a snapshot can load every cycle.
- `rst` during a window: partial window discarded, held snapshot dropped, `out_valid=0` on the next cycle. The first post-reset enabled sample begins a new window.
- `en` sampled in the same cycle as `rst=1`: ignored.
- `hi` wrap at 2^HI_W is silent modular wrap; no flag is raised.

## Structure
- `accum4_pkg`:
  - `ACC_W=4` constant.
  - `accum4_snap_t` struct: total and wraps fields, parameterised by localparams derived from `HI_W` and `WINDOW` in the module.
- Sub-module `accum4_snap_reg`: single-entry output holding register with valid/ready handshake, overwrite, and the overrun flag.
- Window counter and carry logic remain in `accum4_extender`.

## Test plan
- Reset hold 3 cycles, release. All outputs 0. `out_valid` stays 0 with `en=0` for 10 cycles.
- WINDOW=4, HI_W=4, `out_ready=1`, four consecutive `en=1` with `in_data=0xF` starting from `accum=0`:
  - One `out_valid` pulse with `out_total=0x3C`, `out_wraps=3`, `out_overrun=0`.
  - `accum4.accum=0xC` in the same cycle.
- Same stimulus with `en` gaps (pattern 1,0,0,1,1,0,1): identical snapshot. Snapshot appears one cycle after the 4th enabled sample.
- `out_ready=0` for two windows of `in_data=0x1`:
  - First snapshot `out_total=0x04`.
  - Overwritten by `out_total=0x08`, `out_overrun=1`.
  - Raise `out_ready` → single transfer of 0x08.
  - Overrun stays 1 until `rst`.
- Handshake and new snapshot in the same cycle: consumer receives the old total, `out_valid` stays 1 with the new total, `out_overrun=0`.
- Drive total to 0xFE, then a window with `in_data` values 1,1,1,0 → `out_total=0x01` (mod 256).
- Assert `rst` after 2 enabled samples: `out_valid=0`. A fresh full window yields a total counted from 0.

Source files
------------

// File: rtl/accum4_pkg.sv
// accum4_pkg: shared width constant, output FSM states and snapshot sizing helper.
package accum4_pkg;
  localparam int ACC_W = 4;
  typedef enum logic {SNAP_EMPTY, SNAP_HOLD} snap_state_e;
  function automatic int wraps_w(input int window);
    return $clog2(window + 1);
  endfunction
endpackage

// File: rtl/accum4_snap_reg.sv
// accum4_snap_reg: single-entry valid/ready holding register, latest-wins overwrite with sticky overrun.
module accum4_snap_reg
  import accum4_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_overrun
);
  snap_state_e r_state, w_state_nx;
  logic [DW-1:0] r_data;
  logic r_ovr;
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = i_load ? SNAP_HOLD : ((r_state == SNAP_HOLD) && i_ready) ? SNAP_EMPTY : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SNAP_EMPTY;
      r_data  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (i_load) r_data <= i_data;
      // an unaccepted snapshot being replaced is the only overrun source
      if (i_load && (r_state == SNAP_HOLD) && !i_ready) r_ovr <= 1'b1;
    end
  end
  assign o_valid   = (r_state == SNAP_HOLD);
  assign o_data    = r_data;
  assign o_overrun = r_ovr;
endmodule

// File: rtl/accum4_extender.sv
// accum4_extender: rebuilds carries lost to accum4's 4-bit wrap and publishes windowed
// {total, wrap count} snapshots over a valid/ready handshake.
module accum4_extender
  import accum4_pkg::*;
#(
  parameter int HI_W   = 4,
  parameter int WINDOW = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [ACC_W-1:0]              in_data,
  input  logic [ACC_W-1:0]              accum,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W+HI_W-1:0]         out_total,
  output logic [$clog2(WINDOW+1)-1:0]   out_wraps,
  output logic                          out_overrun
);
  localparam int TOT_W = ACC_W + HI_W;
  localparam int WRP_W = wraps_w(WINDOW);
  typedef struct packed {
    logic [TOT_W-1:0] total;
    logic [WRP_W-1:0] wraps;
  } accum4_snap_t;
  logic [HI_W-1:0] r_hi;
  logic [WRP_W-1:0] r_cnt, r_wraps;
  logic [ACC_W:0] w_sum5;
  logic w_carry, w_last;
  logic [HI_W-1:0] w_hi_nx;
  logic [WRP_W-1:0] w_wraps_nx;
  accum4_snap_t w_snap, w_out;
  assign w_sum5     = {1'b0, accum} + {1'b0, in_data};
  assign w_carry    = w_sum5[ACC_W];
  assign w_hi_nx    = r_hi + HI_W'(w_carry);
  assign w_wraps_nx = r_wraps + WRP_W'(w_carry);
  assign w_last     = en && (r_cnt == WRP_W'(WINDOW - 1));
  // snapshot includes this cycle's carry, so the total matches accum4's next value
  assign w_snap     = '{total: {w_hi_nx, w_sum5[ACC_W-1:0]}, wraps: w_wraps_nx};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi    <= '0;
      r_cnt   <= '0;
      r_wraps <= '0;
    end else if (en) begin
      r_hi    <= w_hi_nx;
      r_cnt   <= w_last ? '0 : r_cnt + WRP_W'(1);
      r_wraps <= w_last ? '0 : w_wraps_nx;
    end
  end
  accum4_snap_reg #(.DW($bits(accum4_snap_t))) u_snap (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_last),
    .i_data   (w_snap),
    .i_ready  (out_ready),
    .o_valid  (out_valid),
    .o_data   (w_out),
    .o_overrun(out_overrun)
  );
  assign out_total = w_out.total;
  assign out_wraps = w_out.wraps;
endmodule
